instr_queue_reg: RTL and testbench
==================================

// Module: instr_queue_reg
// PURPOSE
//   Parametrised successor of the single-entry instruction register: a DEPTH-entry
//   instruction buffer between instruction memory and decode/control. Valid/ready on
//   both sides, synchronous flush for branches/jumps, MIPS field extraction at the head.
//   Lets fetch run ahead of a multi-cycle control FSM.
// PARAMETERS
//   WIDTH  32  instruction width in bits; field positions below require WIDTH == 32
//   DEPTH  4   number of entries; power of two, >= 2
// PORTS
//   clk        in   1            rising-edge clock
//   reset_n    in   1            asynchronous, active-low reset
//   flush      in   1            synchronous discard of all entries
//   in_valid   in   1            instr_in is valid this cycle
//   in_ready   out  1            queue can accept an entry
//   instr_in   in   WIDTH        instruction from memory
//   out_valid  out  1            head entry is valid
//   out_ready  in   1            consumer takes the head entry this cycle
//   instr_out  out  WIDTH        head instruction
//   opcode     out  6            instr_out[31:26]
//   Rs         out  5            instr_out[25:21]
//   Rt         out  5            instr_out[20:16]
//   Rd         out  5            instr_out[15:11]
//   imm16      out  16           instr_out[15:0]
//   count      out  $clog2(DEPTH+1)  number of valid entries
// BEHAVIOUR
//   - Reset (reset_n low, async): wr_ptr = rd_ptr = 0, count = 0, all storage = 0;
//     so out_valid=0, in_ready=1, instr_out and all fields = 0. Reset mid-stream
//     drops every entry; no partial state survives.
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = (count != DEPTH); registered-state only, no combinational path from
//     out_ready. A full queue accepts nothing, even when popping in the same cycle.
//   - out_valid = (count != 0). instr_out is the head storage word when out_valid=1,
//     and forced to 0 when empty. Fields are combinational slices of instr_out.
//   - Latency: an entry pushed at edge N is visible at the head after edge N, provided
//     the queue was empty. Order is strict FIFO.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   - flush=1 at an edge: wr_ptr = rd_ptr = 0 and count = 0. Flush dominates any push
//     or pop in the same cycle; the instr_in offered that cycle is discarded. Storage
//     contents need not be cleared because out_valid gates them.
//   - in_valid while in_ready=0: no effect. The producer holds instr_in.
//   - out_ready while out_valid=0: no effect. count never underflows or overflows.
// STRUCTURE
//   - Shared package or header (instr_fields): localparams OPCODE_MSB/LSB, RS_MSB/LSB,
//     RT_MSB/LSB, RD_MSB/LSB, IMM_MSB/LSB. The control FSM and ALU decode reuse them.
//   - Sub-module instr_field_decode: combinational, instr -> opcode/Rs/Rt/Rd/imm16.
//     Also used elsewhere in the datapath.
//   - Top: storage array, wr_ptr/rd_ptr/count registers, handshake logic.
// TESTING
//   1 Reset: hold reset_n=0 with in_valid=1 -> out_valid=0, in_ready=1, count=0,
//     instr_out=0. Release reset -> queue accepts on the next edge.
//   2 Decode: push 32'h8C22_0004 (lw) -> next cycle opcode=6'h23, Rs=1, Rt=2,
//     imm16=16'h0004. Push 32'h0043_0820 (add) -> Rs=2, Rt=3, Rd=1.
//   3 Fill: out_ready=0, push 5 words A0..A4 with DEPTH=4 -> count=4, in_ready=0
//     after the 4th push, A4 not stored. Then drain -> A0..A3 in order, count=0.
//   4 Simultaneous: count=2, push and pop in one cycle -> count stays 2, head advances.
//     Repeat 10 cycles -> pointers wrap, FIFO order preserved.
//   5 Flush: count=3, with in_valid=1 and out_ready=1 in the same cycle assert flush
//     -> count=0, out_valid=0. The offered word is absent after flush.
//   6 Random valid/ready for 1000 cycles against a scoreboard queue -> no mismatch,
//     count always in 0..DEPTH.

Source files
------------

// File: rtl/instr_fields.sv
// instr_fields: MIPS instruction field positions shared by the queue, control FSM and ALU decode.
package instr_fields;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational slicing of a 32-bit MIPS word into its fields.
module instr_field_decode
  import instr_fields::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [15:0] imm16_o
);
  assign opcode_o = instr_i[OPCODE_MSB:OPCODE_LSB];
  assign rs_o     = instr_i[RS_MSB:RS_LSB];
  assign rt_o     = instr_i[RT_MSB:RT_LSB];
  assign rd_o     = instr_i[RD_MSB:RD_LSB];
  assign imm16_o  = instr_i[IMM_MSB:IMM_LSB];
endmodule

// File: rtl/instr_queue_reg.sv
// instr_queue_reg: DEPTH-entry instruction FIFO between fetch and decode with flush
// and field extraction at the head.
module instr_queue_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             instr_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             instr_out,
  output logic [5:0]                   opcode,
  output logic [4:0]                   Rs,
  output logic [4:0]                   Rt,
  output logic [4:0]                   Rd,
  output logic [15:0]                  imm16,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  // in_ready depends only on registered count, so a full queue refuses even while popping
  assign in_ready  = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign instr_out = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  always_comb begin
    wr_ptr_d = flush ? '0 : push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = flush ? '0 : (push && !pop) ? count_q + 1'b1 :
               (pop && !push) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) mem_q[wr_ptr_q] <= instr_in;
    end
  end
  instr_field_decode u_dec (
    .instr_i  (instr_out),
    .opcode_o (opcode),
    .rs_o     (Rs),
    .rt_o     (Rt),
    .rd_o     (Rd),
    .imm16_o  (imm16)
  );
endmodule

// File: tb/tb_instr_queue_reg.sv
// tb_instr_queue_reg: scenario tasks plus a random run checked against a queue model.
module tb_instr_queue_reg;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  logic          clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0]   instr_in = '0;
  logic          in_ready, out_valid;
  logic [31:0]   instr_out;
  logic [5:0]    opcode;
  logic [4:0]    Rs, Rt, Rd;
  logic [15:0]   imm16;
  logic [CW-1:0] count;
  logic [31:0]   model[$];
  int            n_checks = 0, n_fail = 0;

  instr_queue_reg #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
    .opcode(opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .imm16(imm16), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] head();
    return model.size() != 0 ? model[0] : 32'h0;
  endfunction

  // drive one cycle from a negedge, update the model at the posedge, return at the next negedge
  task automatic cyc(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    bit p, q;
    flush = fl; in_valid = iv; instr_in = d; out_ready = ordy;
    @(posedge clk);
    if (fl) model.delete();
    else begin
      p = iv && model.size() < DEPTH;
      q = ordy && model.size() > 0;
      if (q) void'(model.pop_front());
      if (p) model.push_back(d);
    end
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; in_valid = 1; instr_in = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0 || instr_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%b ready=%b count=%0d out=%h, required 0 1 0 00000000",
               out_valid, in_ready, count, instr_out);
    end
    in_valid = 0; reset_n = 1;
    cyc(0, 1, 32'h1234_5678, 0);
    n_checks++;
    if (out_valid !== 1'b1 || instr_out !== 32'h1234_5678 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b out=%h count=%0d, required 1 12345678 1",
               out_valid, instr_out, count);
    end
    cyc(0, 1, 32'h9ABC_DEF0, 0);
    #2 reset_n = 0;
    #1;
    model.delete();
    n_checks++;
    if (out_valid !== 1'b0 || count !== '0 || instr_out !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midstream: valid=%b count=%0d out=%h ready=%b, required 0 0 00000000 1",
               out_valid, count, instr_out, in_ready);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_decode();
    cyc(0, 1, 32'h8C22_0004, 0);
    n_checks++;
    if (opcode !== 6'h23 || Rs !== 5'd1 || Rt !== 5'd2 || imm16 !== 16'h0004) begin
      n_fail++;
      $display("FAIL decode_lw: opcode=%h Rs=%0d Rt=%0d imm=%h, required 23 1 2 0004",
               opcode, Rs, Rt, imm16);
    end
    cyc(0, 1, 32'h0043_0820, 1);
    n_checks++;
    if (opcode !== 6'h00 || Rs !== 5'd2 || Rt !== 5'd3 || Rd !== 5'd1 || instr_out !== 32'h0043_0820) begin
      n_fail++;
      $display("FAIL decode_add: opcode=%h Rs=%0d Rt=%0d Rd=%0d out=%h, required 00 2 3 1 00430820",
               opcode, Rs, Rt, Rd, instr_out);
    end
    cyc(0, 0, 0, 1);
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0 || opcode !== 6'h0) begin
      n_fail++;
      $display("FAIL decode_drain: count=%0d valid=%b opcode=%h, required 0 0 00", count, out_valid, opcode);
    end
  endtask

  task automatic test_fill();
    logic [31:0] a [5];
    int exp_cnt;
    for (int i = 0; i < 5; i++) a[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, a[i], 0);
      exp_cnt = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      n_checks++;
      if (count !== CW'(exp_cnt) || in_ready !== (i + 1 < DEPTH) || instr_out !== a[0]) begin
        n_fail++;
        $display("FAIL fill_%0d: count=%0d ready=%b head=%h, required %0d %b %h",
                 i, count, in_ready, instr_out, exp_cnt, (i + 1 < DEPTH), a[0]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || instr_out !== a[i]) begin
        n_fail++;
        $display("FAIL drain_%0d: valid=%b head=%h, required 1 %h", i, out_valid, instr_out, a[i]);
      end
      cyc(0, 0, 0, 1);
    end
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0 || instr_out !== 32'h0) begin
      n_fail++;
      $display("FAIL fill_empty: count=%0d valid=%b out=%h, required 0 0 00000000", count, out_valid, instr_out);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] b [12];
    for (int i = 0; i < 12; i++) b[i] = 32'hB000_0000 + 32'(i * 3);
    cyc(0, 1, b[0], 0);
    cyc(0, 1, b[1], 0);
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (count !== CW'(2) || instr_out !== b[k]) begin
        n_fail++;
        $display("FAIL simul_%0d: count=%0d head=%h, required 2 %h", k, count, instr_out, b[k]);
      end
      cyc(0, 1, b[k+2], 1);
    end
    n_checks++;
    if (count !== CW'(2) || instr_out !== b[10]) begin
      n_fail++;
      $display("FAIL simul_end: count=%0d head=%h, required 2 %h", count, instr_out, b[10]);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hC000_0000 + 32'(i), 0);
    n_checks++;
    if (count !== CW'(3)) begin
      n_fail++;
      $display("FAIL flush_pre: count=%0d, required 3", count);
    end
    cyc(1, 1, 32'hDEAD_BEEF, 1);
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: count=%0d valid=%b ready=%b, required 0 0 1", count, out_valid, in_ready);
    end
    cyc(0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0 || instr_out !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_absent: valid=%b out=%h, required 0 00000000", out_valid, instr_out);
    end
    cyc(0, 1, 32'h1111_2222, 0);
    n_checks++;
    if (count !== CW'(1) || instr_out !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL flush_after: count=%0d head=%h, required 1 11112222", count, instr_out);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int c = 0; c < 1000; c++) begin
      cyc($urandom_range(31) == 0, 1'($urandom), $urandom, 1'($urandom));
      e = head();
      n_checks++;
      if (count > CW'(DEPTH) || count !== CW'(model.size()) || out_valid !== (model.size() != 0) ||
          in_ready !== (model.size() != DEPTH) || instr_out !== e || opcode !== e[31:26] ||
          Rs !== e[25:21] || Rt !== e[20:16] || Rd !== e[15:11] || imm16 !== e[15:0]) begin
        n_fail++;
        $display("FAIL random_%0d: count=%0d valid=%b ready=%b out=%h, required %0d %b %b %h",
                 c, count, out_valid, in_ready, instr_out, model.size(), model.size() != 0,
                 model.size() != DEPTH, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_fill();
    test_simultaneous();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
